ucode_sequencer: RTL and testbench

Microcode sequencer that drives the four 8Kx8 microcode ROMs and consumes their data. Generates the 13-bit ROM address from the latched opcode, a step counter and a condition flag, and drives the ROM chip controls. It registers the 32-bit control word for the datapath and handles step advance, end-of-instruction, opcode load, stall and step overflow. Sits between the instruction register input and the control-word bus.

---
 rtl/ucode_sequencer_if.sv | 35 +++
 rtl/ucode_sequencer.sv | 95 +++++++++
 tb/tb_ucode_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ucode_sequencer_if.sv
// Bus bundle between the microcode sequencer, its four 8Kx8 ROMs, the
// instruction fetch path and the datapath control-word consumer.
interface ucode_sequencer_if;
    logic [7:0]  opcode_in;
    logic        cond_in;
    logic        stall;
    logic [12:0] rom_a;
    logic        rom_nce;
    logic        rom_noe;
    logic        rom_nwe;
    logic [7:0]  rom_d0;
    logic [7:0]  rom_d1;
    logic [7:0]  rom_d2;
    logic [7:0]  rom_d3;
    logic [31:0] ctrl;
    logic        ctrl_valid;
    logic [3:0]  step;
    logic        ucode_err;

    // Sequencer side
    modport master (
        input  opcode_in, cond_in, stall,
        input  rom_d0, rom_d1, rom_d2, rom_d3,
        output rom_a, rom_nce, rom_noe, rom_nwe,
        output ctrl, ctrl_valid, step, ucode_err
    );

    // Environment side: fetch path, ROMs and datapath
    modport slave (
        output opcode_in, cond_in, stall,
        output rom_d0, rom_d1, rom_d2, rom_d3,
        input  rom_a, rom_nce, rom_noe, rom_nwe,
        input  ctrl, ctrl_valid, step, ucode_err
    );
endinterface

// File: rtl/ucode_sequencer.sv
// Microcode sequencer: addresses the four async microcode ROMs from {cond, opcode, step}
// and registers the 32-bit control word. Optional step-overflow guard: UCODE_STEP_GUARD_EN.
module ucode_sequencer #(
    parameter int STEP_BITS = 4,
    parameter int END_BIT   = 31,
    parameter int IRLD_BIT  = 30,
    parameter int CSEL_BIT  = 29
) (
    input  logic              clk,
    input  logic              rst,
    ucode_sequencer_if.master bus
);
    typedef enum logic {S_OFF = 1'b0, S_RUN = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [STEP_BITS-1:0] step_q, step_d;
    logic [7:0]           opc_q, opc_d;
    logic                 csel_q, csel_d;
    logic [31:0]          ctrl_q, ctrl_d;
    logic                 ctrl_valid_q, ctrl_valid_d;
    logic                 err_q, err_d;

    logic        en_q;
    logic        adv;
    logic [31:0] w;

    assign en_q = (state_q == S_RUN);
    assign adv  = en_q & ~bus.stall;
    // ROMs are asynchronous: the word for rom_a is usable in the same cycle
    assign w    = {bus.rom_d3, bus.rom_d2, bus.rom_d1, bus.rom_d0};

    assign bus.rom_a      = {csel_q & bus.cond_in, opc_q, step_q};
    assign bus.rom_nce    = ~en_q;
    assign bus.rom_noe    = ~en_q;
    assign bus.rom_nwe    = 1'b1;
    assign bus.ctrl       = ctrl_q;
    assign bus.ctrl_valid = ctrl_valid_q;
    assign bus.step       = step_q;
    assign bus.ucode_err  = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_OFF;
            step_q       <= '0;
            opc_q        <= '0;
            csel_q       <= 1'b0;
            ctrl_q       <= '0;
            ctrl_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            opc_q        <= opc_d;
            csel_q       <= csel_d;
            ctrl_q       <= ctrl_d;
            ctrl_valid_q <= ctrl_valid_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        opc_d        = opc_q;
        csel_d       = csel_q;
        ctrl_d       = ctrl_q;
        ctrl_valid_d = adv;
        err_d        = err_q;

        case (state_q)
            S_OFF:   state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_OFF;
        endcase

        if (adv) begin
            ctrl_d = w;
            step_d = w[END_BIT] ? '0 : step_q + STEP_BITS'(1);
            if (w[IRLD_BIT]) begin
                opc_d = bus.opcode_in;
            end
            // A branch select never survives into the next instruction
            csel_d = w[CSEL_BIT] & ~w[END_BIT];
`ifdef UCODE_STEP_GUARD_EN
            if ((step_q == '1) && !w[END_BIT]) begin
                err_d = 1'b1;
            end
`endif
        end

`ifndef UCODE_STEP_GUARD_EN
        err_d = 1'b0;
`endif
    end
endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer with a ROM image model and a control-word scoreboard.
module tb_ucode_sequencer;
    logic clk;
    logic rst;
    logic [31:0] mem [0:8191];
    logic [31:0] exp_q [$];
    logic [31:0] last_ctrl;
    logic        exp_err;
    int n_chk;
    int n_pass;

    ucode_sequencer_if bus();

    ucode_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rom_d0 = mem[bus.rom_a][7:0];
    assign bus.rom_d1 = mem[bus.rom_a][15:8];
    assign bus.rom_d2 = mem[bus.rom_a][23:16];
    assign bus.rom_d3 = mem[bus.rom_a][31:24];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one cycle: check address, push the expected word if unstalled,
    // then after the edge check the registered control word.
    task automatic cyc(input string tag, input logic [12:0] ea, input logic st);
        logic [31:0] e;
        bus.stall = st;
        #1;
        chk({tag, ".rom_a"}, 32'(bus.rom_a), 32'(ea));
        chk({tag, ".step"}, 32'(bus.step), 32'(ea[3:0]));
        if (!st) exp_q.push_back(mem[ea]);
        @(posedge clk);
        #1;
        if (!st) begin
            chk({tag, ".valid"}, 32'(bus.ctrl_valid), 32'd1);
            if (exp_q.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk({tag, ".ctrl"}, bus.ctrl, e);
                last_ctrl = e;
            end
        end else begin
            chk({tag, ".stall_valid"}, 32'(bus.ctrl_valid), 32'd0);
            chk({tag, ".stall_ctrl"}, bus.ctrl, last_ctrl);
        end
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        last_ctrl = 32'h0;
`ifdef UCODE_STEP_GUARD_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
        mem[13'h000] = 32'h4000_0001;
        mem[13'h0A50] = 32'h0000_0010;
        mem[13'h0A51] = 32'h2000_0011;
        mem[13'h0A52] = 32'h8000_0012;
        mem[13'h1A52] = 32'hC000_0112;
        for (int k = 0; k < 16; k++) mem[13'h03C0 + k] = 32'(k);

        rst = 1'b1;
        bus.opcode_in = 8'h00;
        bus.cond_in = 1'b0;
        bus.stall = 1'b0;
        repeat (3) tick();
        chk("rst.nce", 32'(bus.rom_nce), 32'd1);
        chk("rst.noe", 32'(bus.rom_noe), 32'd1);
        chk("rst.nwe", 32'(bus.rom_nwe), 32'd1);
        chk("rst.ctrl", bus.ctrl, 32'h0);
        chk("rst.valid", 32'(bus.ctrl_valid), 32'd0);
        chk("rst.step", 32'(bus.step), 32'd0);
        chk("rst.err", 32'(bus.ucode_err), 32'd0);
        chk("rst.rom_a", 32'(bus.rom_a), 32'h0);

        // Release: ROMs stay off for the first cycle
        rst = 1'b0;
        bus.opcode_in = 8'hA5;
        #1;
        chk("rel.nce_first", 32'(bus.rom_nce), 32'd1);
        tick();
        chk("rel.nce_on", 32'(bus.rom_nce), 32'd0);
        chk("rel.noe_on", 32'(bus.rom_noe), 32'd0);
        chk("rel.valid_off", 32'(bus.ctrl_valid), 32'd0);

        cyc("fetch0", 13'h000, 1'b0);
        cyc("a5s1", 13'h0A51, 1'b0);
        cyc("a5s2_end", 13'h0A52, 1'b0);
        cyc("a5s0", 13'h0A50, 1'b0);
        for (int s = 0; s < 3; s++) cyc("stall", 13'h0A51, 1'b1);
        cyc("a5s1_rel", 13'h0A51, 1'b0);

        // Branch taken into the END+IRLD word; new opcode loads
        bus.cond_in = 1'b1;
        bus.opcode_in = 8'h3C;
        cyc("br_taken", 13'h1A52, 1'b0);
        chk("br.nwe", 32'(bus.rom_nwe), 32'd1);

        for (int k = 0; k < 16; k++) begin
            if (k == 15) chk("ovf.err_before", 32'(bus.ucode_err), 32'd0);
            cyc("ovf", 13'h03C0 + 13'(k), 1'b0);
        end
        chk("ovf.err", 32'(bus.ucode_err), 32'(exp_err));
        cyc("wrap0", 13'h03C0, 1'b0);
        cyc("wrap1", 13'h03C1, 1'b0);
        cyc("wrap2", 13'h03C2, 1'b0);
        chk("ovf.err_sticky", 32'(bus.ucode_err), 32'(exp_err));

        // Abort mid-instruction at step 3
        rst = 1'b1;
        tick();
        chk("abort.step", 32'(bus.step), 32'd0);
        chk("abort.rom_a", 32'(bus.rom_a), 32'h0);
        chk("abort.ctrl", bus.ctrl, 32'h0);
        chk("abort.valid", 32'(bus.ctrl_valid), 32'd0);
        chk("abort.nce", 32'(bus.rom_nce), 32'd1);
        chk("abort.err", 32'(bus.ucode_err), 32'd0);
        chk("sb.drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
